// File: rtl/life_gen_sequencer.sv
// life_gen_sequencer: runs one B3/S23 generation from the front bank into the back bank, then swaps banks
module life_gen_sequencer #(
    parameter int ROWS   = 30,
    parameter int COLS   = 40,
    parameter int AW     = 5,
    parameter int PERIOD = 25_000_000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            run,
    output logic            busy,
    output logic            step_done,
    output logic            front_bank,
    output logic [15:0]     gen_count,
    output logic [AW-1:0]   rd_addr,
    input  logic [COLS-1:0] rd_data,
    output logic            wr_en,
    output logic [AW-1:0]   wr_addr,
    output logic [COLS-1:0] wr_data
);
    typedef enum logic [2:0] {IDLE, PRIME0, PRIME1, STEP, SWAP} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   row_q, row_d;
    logic [COLS-1:0] above_q, above_d, cur_q, cur_d, below_in;
    logic            front_bank_q, front_bank_d;
    logic [15:0]     gen_count_q, gen_count_d;
    logic [23:0]     timer_q, timer_d;
    logic            tick;
    logic [AW:0]     rd_next;

    // Shifting zeros in at both ends makes the off-board columns dead
    function automatic logic [COLS-1:0] life_row(input logic [COLS-1:0] a, c, b);
        logic [COLS-1:0] al, ar, cl, cr, bl, br;
        logic [3:0]      n;
        al = a >> 1; ar = a << 1;
        cl = c >> 1; cr = c << 1;
        bl = b >> 1; br = b << 1;
        for (int i = 0; i < COLS; i++) begin
            n = {3'b0, al[i]} + {3'b0, a[i]} + {3'b0, ar[i]} + {3'b0, cl[i]}
              + {3'b0, cr[i]} + {3'b0, bl[i]} + {3'b0, b[i]} + {3'b0, br[i]};
            life_row[i] = (n == 4'd3) || (c[i] && n == 4'd2);
        end
    endfunction

    always_comb begin
        tick         = run && timer_q == 24'(PERIOD - 1);
        timer_d      = (run && !tick) ? timer_q + 24'd1 : '0;
        below_in     = (row_q == AW'(ROWS - 1)) ? '0 : rd_data;
        rd_next      = {1'b0, row_q} + (AW + 1)'(2);
        state_d      = state_q;
        row_d        = row_q;
        above_d      = above_q;
        cur_d        = cur_q;
        front_bank_d = front_bank_q;
        gen_count_d  = gen_count_q;
        rd_addr      = '0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        case (state_q)
            IDLE:   state_d = (start || tick) ? PRIME0 : IDLE;
            PRIME0: state_d = PRIME1;
            PRIME1: begin
                rd_addr = AW'(1);
                above_d = '0;
                cur_d   = rd_data;
                row_d   = '0;
                state_d = STEP;
            end
            STEP: begin
                wr_en   = 1'b1;
                wr_addr = row_q;
                wr_data = life_row(above_q, cur_q, below_in);
                rd_addr = (rd_next < (AW + 1)'(ROWS)) ? rd_next[AW-1:0] : '0;
                above_d = cur_q;
                cur_d   = below_in;
                row_d   = row_q + AW'(1);
                state_d = (row_q == AW'(ROWS - 1)) ? SWAP : STEP;
            end
            SWAP: begin
                front_bank_d = ~front_bank_q;
                gen_count_d  = gen_count_q + 16'd1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            row_q        <= '0;
            above_q      <= '0;
            cur_q        <= '0;
            front_bank_q <= 1'b0;
            gen_count_q  <= '0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            above_q      <= above_d;
            cur_q        <= cur_d;
            front_bank_q <= front_bank_d;
            gen_count_q  <= gen_count_d;
            timer_q      <= timer_d;
        end
    end

    assign busy       = state_q != IDLE;
    assign step_done  = state_q == SWAP;
    assign front_bank = front_bank_q;
    assign gen_count  = gen_count_q;
endmodule

// File: tb/tb_life_gen_sequencer.sv
// tb_life_gen_sequencer: directed boards with a write/step_done scoreboard against the bench RAM model
module tb_life_gen_sequencer;
    localparam int ROWS = 30, COLS = 40, AW = 5, PERIOD = 100;

    logic            clk = 1'b0, reset_n = 1'b0, start = 1'b0, run = 1'b0;
    logic            busy, step_done, front_bank, wr_en;
    logic [15:0]     gen_count;
    logic [AW-1:0]   rd_addr, wr_addr;
    logic [COLS-1:0] rd_data = '0, wr_data;

    life_gen_sequencer #(.ROWS(ROWS), .COLS(COLS), .AW(AW), .PERIOD(PERIOD)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .run(run), .busy(busy),
        .step_done(step_done), .front_bank(front_bank), .gen_count(gen_count),
        .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    logic [COLS-1:0] mem [2][ROWS];
    logic [COLS-1:0] init_img [ROWS];
    logic [COLS-1:0] exp_img [ROWS];
    logic            load_req = 1'b0;
    int              cyc = 0;
    int              n_vec = 0, n_err = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rd_data <= (rd_addr < AW'(ROWS)) ? mem[front_bank][rd_addr] : '0;
        if (load_req)
            for (int r = 0; r < ROWS; r++) begin
                mem[front_bank][r]  <= init_img[r];
                mem[~front_bank][r] <= '0;
            end
        else if (wr_en && wr_addr < AW'(ROWS))
            mem[~front_bank][wr_addr] <= wr_data;
    end

    logic [AW+COLS-1:0] q_wr [$];
    int                 q_dcyc [$];
    logic [16:0]        q_dst [$];
    logic               m_fb = 1'b0;
    logic [15:0]        m_gc = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    logic        post = 1'b0;
    logic [16:0] post_st;
    logic [AW+COLS-1:0] w;
    always @(negedge clk) begin
        if (post) begin
            chk("fb_after", {63'b0, front_bank}, {63'b0, post_st[16]});
            chk("gc_after", {48'b0, gen_count}, {48'b0, post_st[15:0]});
            post = 1'b0;
        end
        if (wr_en) begin
            if (q_wr.size() == 0) chk("unexpected_wr", {59'b0, wr_addr}, 64'hFFFF);
            else begin
                w = q_wr.pop_front();
                chk("wr_addr", {59'b0, wr_addr}, {59'b0, w[AW+COLS-1:COLS]});
                chk("wr_data", {24'b0, wr_data}, {24'b0, w[COLS-1:0]});
            end
        end
        if (step_done) begin
            if (q_dcyc.size() == 0) chk("unexpected_done", 64'(cyc), 64'hFFFF);
            else begin
                chk("done_cycle", 64'(cyc), 64'(q_dcyc.pop_front()));
                post_st = q_dst.pop_front();
                chk("fb_at_done", {63'b0, front_bank}, {63'b0, ~post_st[16]});
                chk("busy_at_done", {63'b0, busy}, 64'd1);
                post = 1'b1;
            end
        end
    end

    function automatic logic [COLS-1:0] cb(input int c);
        logic [COLS-1:0] v;
        v = '0;
        v[COLS-1-c] = 1'b1;
        return v;
    endfunction

    task automatic clear_imgs();
        for (int r = 0; r < ROWS; r++) begin
            init_img[r] = '0;
            exp_img[r]  = '0;
        end
    endtask

    task automatic load();
        @(negedge clk); load_req = 1'b1;
        @(negedge clk); load_req = 1'b0;
    endtask

    task automatic push_step(input int launch);
        for (int r = 0; r < ROWS; r++) q_wr.push_back({AW'(r), exp_img[r]});
        m_fb = ~m_fb;
        m_gc = m_gc + 16'd1;
        q_dcyc.push_back(launch + 33);
        q_dst.push_back({m_fb, m_gc});
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1; push_step(cyc);
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int t = 0;
        while ((q_wr.size() != 0 || q_dcyc.size() != 0 || post) && t < 3000) begin
            @(negedge clk); t++;
        end
        chk(nm, 64'(q_wr.size() + q_dcyc.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int s;
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < ROWS; r++) mem[b][r] = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, step_done}, 64'd0);
        chk("rst_wr_en", {63'b0, wr_en}, 64'd0);
        chk("rst_fb", {63'b0, front_bank}, 64'd0);
        chk("rst_gc", {48'b0, gen_count}, 64'd0);
        chk("rst_rd_addr", {59'b0, rd_addr}, 64'd0);
        chk("rst_wr_addr", {59'b0, wr_addr}, 64'd0);
        chk("rst_wr_data", {24'b0, wr_data}, 64'd0);
        reset_n = 1'b1;
        // Blinker flips horizontal to vertical
        clear_imgs();
        init_img[14] = cb(18) | cb(19) | cb(20);
        exp_img[13] = cb(19); exp_img[14] = cb(19); exp_img[15] = cb(19);
        load(); do_start(); wait_idle("t1_drain");
        // Top-left block is a still life
        clear_imgs();
        init_img[0] = cb(0) | cb(1); init_img[1] = cb(0) | cb(1);
        exp_img[0] = cb(0) | cb(1); exp_img[1] = cb(0) | cb(1);
        load(); do_start(); wait_idle("t2_drain");
        // Bottom-right L completes to a block
        clear_imgs();
        init_img[28] = cb(39); init_img[29] = cb(38) | cb(39);
        exp_img[28] = cb(38) | cb(39); exp_img[29] = cb(38) | cb(39);
        load(); do_start(); wait_idle("t3_drain");
        // Full board: only the four corners survive
        clear_imgs();
        for (int r = 0; r < ROWS; r++) init_img[r] = '1;
        exp_img[0] = cb(0) | cb(39); exp_img[ROWS-1] = cb(0) | cb(39);
        load(); do_start(); wait_idle("t4_drain");
        // Auto-step with a coincident start and a start during STEP
        clear_imgs();
        load();
        @(negedge clk); s = cyc; run = 1'b1;
        for (int k = 0; k < 10; k++) push_step(s + 99 + 100 * k);
        for (int i = 1; i <= 1000; i++) begin
            @(negedge clk);
            start = (cyc == s + 99) || (cyc == s + 214);
        end
        run = 1'b0; start = 1'b0;
        wait_idle("t5_drain");
        chk("t5_gc", {48'b0, gen_count}, 64'd14);
        // Reset in the middle of a step
        clear_imgs();
        init_img[14] = cb(18) | cb(19) | cb(20);
        load();
        @(negedge clk); start = 1'b1; s = cyc;
        for (int r = 0; r <= 10; r++) q_wr.push_back({AW'(r), {COLS{1'b0}}});
        @(negedge clk); start = 1'b0;
        repeat (12) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("t6_busy", {63'b0, busy}, 64'd0);
        chk("t6_wr_en", {63'b0, wr_en}, 64'd0);
        chk("t6_fb", {63'b0, front_bank}, 64'd0);
        chk("t6_gc", {48'b0, gen_count}, 64'd0);
        chk("t6_wrq", 64'(q_wr.size()), 64'd0);
        reset_n = 1'b1;
        m_fb = 1'b0; m_gc = '0;
        exp_img[13] = cb(19); exp_img[14] = cb(19); exp_img[15] = cb(19);
        load(); do_start(); wait_idle("t6_drain");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
